// File: rtl/apb4_bridge_pkg.sv
// Shared types and constants for the APB4 round-robin requester bridge.
package apb4_bridge_pkg;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } state_t;

  // Each peripheral owns one PERIPH_STRIDE-byte window; the peripheral
  // index is the address shifted right by IDX_LSB.
  localparam int PERIPH_STRIDE = 16;
  localparam int IDX_LSB       = $clog2(PERIPH_STRIDE);

  // Read data returned on decode errors and timeouts (sliced to DATA_WIDTH).
  localparam logic [31:0] ERR_RDATA = '1;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb4_rr_bridge_arbiter.sv
// Round-robin arbiter: combinational grant search starting at a pointer,
// pointer advances past the winner whenever a grant is issued.
module rr_arbiter
  import apb4_bridge_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any_grant
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cand;
  logic             found;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign any_grant = enable && found;
  assign grant     = any_grant ? (NUM_REQ'(1) << winner) : '0;

  // Pointer moves to the requester after the winner on every grant.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!PRESETn) begin
      ptr_q <= '0;
    end else if (any_grant) begin
      ptr_q <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/apb4_rr_bridge.sv
// APB4 requester bridge: round-robin shares one APB4 bus between NUM_REQ
// request ports, sequences SETUP/ACCESS, decodes one-hot PSEL from 16-byte
// windows, aborts stalled transfers and routes responses to the winner.
module apb4_rr_bridge
  import apb4_bridge_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_PERIPH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb,
  input  logic [NUM_REQ*3-1:0]             req_prot,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [2:0]                       PPROT,
  output logic [NUM_PERIPH-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_PERIPH-1:0]            PREADY,
  input  logic [NUM_PERIPH-1:0]            PSLVERR
);

  localparam int PTR_W  = idx_width(NUM_REQ);
  localparam int SEL_W  = idx_width(NUM_PERIPH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic              arb_en, arb_any;
  logic [PTR_W-1:0]  arb_winner;
  logic [PTR_W-1:0]  owner_q;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_write;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [STRB_W-1:0]     win_strb;
  logic [2:0]            win_prot;
  logic [ADDR_WIDTH-1:0] dec_idx;
  logic [SEL_W-1:0]      dec_sel;
  logic                  dec_ok;

  logic                  ready_sel, slverr_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  done, abort;

  // Only the selected peripheral's handshake matters.
  assign ready_sel  = PREADY[sel_q];
  assign slverr_sel = PSLVERR[sel_q];
  assign rdata_sel  = PRDATA[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

  assign done  = (state_q == ACCESS) && ready_sel;
  assign abort = (state_q == ACCESS) && !ready_sel && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Arbitrate when idle or in the ACCESS cycle that completes; never during reset.
  assign arb_en = PRESETn && ((state_q == IDLE) || done);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .enable    (arb_en),
    .valid     (req_valid),
    .grant     (req_grant),
    .winner    (arb_winner),
    .any_grant (arb_any)
  );

  // Winner's request fields and address decode.
  assign win_addr  = req_addr[int'(arb_winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_write = req_write[arb_winner];
  assign win_wdata = req_wdata[int'(arb_winner)*DATA_WIDTH +: DATA_WIDTH];
  assign win_strb  = req_strb[int'(arb_winner)*STRB_W +: STRB_W];
  assign win_prot  = req_prot[int'(arb_winner)*3 +: 3];
  assign dec_idx   = win_addr >> IDX_LSB;
  assign dec_ok    = dec_idx < ADDR_WIDTH'(NUM_PERIPH);
  assign dec_sel   = dec_ok ? dec_idx[SEL_W-1:0] : '0;

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = dec_ok ? SETUP : DECERR;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done)       state_d = arb_any ? (dec_ok ? SETUP : DECERR) : IDLE;
        else if (abort) state_d = IDLE;
      end
      DECERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered APB and response outputs, plus transfer bookkeeping.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR     <= '0;
      PPROT     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      owner_q   <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
    end else begin
      rsp_valid <= '0;

      // Responses use the owner of the finishing transfer.
      if (done) begin
        rsp_valid <= NUM_REQ'(1) << owner_q;
        rsp_err   <= slverr_sel;
        rsp_rdata <= PWRITE ? '0 : rdata_sel;
      end else if (abort || (state_q == DECERR)) begin
        rsp_valid <= NUM_REQ'(1) << owner_q;
        rsp_err   <= 1'b1;
        rsp_rdata <= ERR_RDATA[DATA_WIDTH-1:0];
      end

      if (state_q == SETUP) PENABLE <= 1'b1;

      if ((state_q == ACCESS) && !ready_sel) cnt_q <= cnt_q + 1'b1;

      // Bus goes quiet when a transfer ends with nothing queued behind it.
      if ((done && !arb_any) || abort) begin
        PSEL    <= '0;
        PENABLE <= 1'b0;
      end

      // Latch a newly granted request; a bad decode leaves PSEL low.
      if (arb_any) begin
        PADDR   <= win_addr;
        PPROT   <= win_prot;
        PWRITE  <= win_write;
        PWDATA  <= win_wdata;
        PSTRB   <= win_strb;
        PSEL    <= dec_ok ? (NUM_PERIPH'(1) << dec_sel) : '0;
        PENABLE <= 1'b0;
        owner_q <= arb_winner;
        sel_q   <= dec_sel;
        cnt_q   <= '0;
      end
    end
  end

endmodule
